// File: rtl/nios_system_oci_dct_pkg.sv
// ---------------------------------------------------------------------------
// nios_system_oci_dct_pkg
//
// Shared definitions for the OCI direct-trace (DCT) producer path:
//   - buffer geometry (DCT_ENTRIES entries of CODE_W bits each)
//   - the 36-bit trace frame layout and its packed struct
//   - branch-direction code values written by the CPU trace tap
//
// Frame layout (MSB first):
//   [35]    ovf      one or more codes were dropped before this frame
//   [34]    partial  frame was flushed before the buffer filled
//   [33:30] count    number of valid entries in the buffer field
//   [29:0]  buffer   entry i at bits [2i+1:2i], unused entries zero
// ---------------------------------------------------------------------------
package nios_system_oci_dct_pkg;

  // Buffer geometry. The count field is 4 bits, so DCT_ENTRIES may not
  // exceed 15. CODE_W is fixed at 2.
  localparam int DCT_ENTRIES = 15;
  localparam int CODE_W      = 2;
  localparam int BUF_W       = CODE_W * DCT_ENTRIES;

  // Frame field positions inside the 36-bit tw_data word.
  localparam int FRAME_W     = 36;
  localparam int OVF_BIT     = 35;
  localparam int PARTIAL_BIT = 34;
  localparam int COUNT_MSB   = 33;
  localparam int COUNT_LSB   = 30;
  localparam int BUF_MSB     = 29;
  localparam int BUF_LSB     = 0;

  typedef struct packed {
    logic        ovf;
    logic        partial;
    logic [3:0]  count;
    logic [29:0] buffer;
  } frame_t;

  // Branch-direction codes. 2'b00 is never produced by the trace tap.
  localparam logic [CODE_W-1:0] NT  = 2'b01;
  localparam logic [CODE_W-1:0] TK  = 2'b10;
  localparam logic [CODE_W-1:0] IND = 2'b11;

  // Assemble a frame word from its fields.
  function automatic frame_t make_frame(input logic        ovf,
                                        input logic        partial,
                                        input logic [3:0]  count,
                                        input logic [29:0] buffer);
    frame_t f;
    f.ovf     = ovf;
    f.partial = partial;
    f.count   = count;
    f.buffer  = buffer;
    return f;
  endfunction

endpackage

// File: rtl/nios_system_nios2_oci_dct_frame_reg.sv
// ---------------------------------------------------------------------------
// nios_system_nios2_oci_dct_frame_reg
//
// One-entry valid/ready output register for DCT trace frames.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   load       in   capture load_data this edge (only when slot_free)
//   load_data  in   frame to capture
//   ready      in   downstream accepts the held frame
//   valid      out  register holds a frame
//   data       out  held frame; stable while valid && !ready
//   slot_free  out  register can accept a frame this cycle
// ---------------------------------------------------------------------------
module nios_system_nios2_oci_dct_frame_reg
  import nios_system_oci_dct_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  frame_t load_data,
  input  logic   ready,
  output logic   valid,
  output frame_t data,
  output logic   slot_free
);

  // The slot is free when empty or when the held frame leaves this edge,
  // which lets a new frame be loaded back-to-back every cycle.
  assign slot_free = !valid || ready;

  // Valid flag: a load always wins, otherwise an accepted frame empties
  // the register and an unaccepted frame is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Frame payload only changes on a load, so it stays stable while the
  // downstream side is stalling. Reset clears it so tw_data reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/nios_system_nios2_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// nios_system_nios2_oci_dct_packer
//
// Producer side of the OCI direct-trace buffer. Packs 2-bit branch
// direction codes into a DCT_ENTRIES-entry buffer and emits full or
// flushed buffers as 36-bit frames over a valid/ready handshake. The
// upstream trace tap cannot be stalled, so codes arriving with no space
// are dropped and reported through the frame ovf bit.
//
// Optional feature: define NIOS_SYSTEM_DCT_OVF_COUNT_EN to add the
// ovf_count port, an 8-bit saturating count of dropped codes.
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   dct_code        in   direction code, sampled when dct_valid
//   dct_valid       in   code-present strobe, one code per cycle
//   flush           in   single-cycle request to emit a partial frame
//   test_ending     in   level, acts as a continuous flush request
//   tw_ready        in   downstream accepts a frame
//   tw_valid        out  frame register occupied
//   tw_data         out  {ovf, partial, count[3:0], buffer[29:0]}
//   dct_buffer      out  live buffer, entry i at bits [2i+1:2i]
//   dct_count       out  live entry count
//   test_has_ended  out  sticky drain-complete indication
//   ovf_count       out  dropped-code count (optional feature only)
// ---------------------------------------------------------------------------
module nios_system_nios2_oci_dct_packer
  import nios_system_oci_dct_pkg::*;
#(
  // Entries in the buffer; legal range 1..15 because the count is 4 bits.
  parameter int ENTRIES = DCT_ENTRIES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       dct_code,
  input  logic                    dct_valid,
  input  logic                    flush,
  input  logic                    test_ending,
  input  logic                    tw_ready,
  output logic                    tw_valid,
  output logic [FRAME_W-1:0]      tw_data,
  output logic [CODE_W*ENTRIES-1:0] dct_buffer,
  output logic [3:0]              dct_count,
  output logic                    test_has_ended
`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
  ,
  output logic [7:0]              ovf_count
`endif
);

  localparam int BW = CODE_W * ENTRIES;

  logic [BW-1:0] buf_q;
  logic [BW-1:0] buf_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          flush_pend_q;
  logic          test_seen_q;
  logic          ended_q;

  logic          full;
  logic          slot_free;
  logic          xfer;
  logic          drop;
  frame_t        frame_in;
  frame_t        frame_out;

  assign full = (cnt_q == 4'(ENTRIES));

  // A frame leaves the buffer when it is full, or when a flush is pending
  // and there is something to send, provided the output slot can take it.
  assign xfer = (full || (flush_pend_q && (cnt_q != 4'd0))) && slot_free;

  // A code is lost only when the buffer is full and cannot be emptied into
  // the frame register this cycle.
  assign drop = dct_valid && full && !xfer;

  // Frame contents are taken straight from the live state. Unused entries
  // are already zero because the buffer is cleared on every transfer.
  always_comb begin
    frame_in = make_frame(ovf_q, !full, cnt_q, 30'(buf_q));
  end

  // Next buffer state. On a transfer the buffer restarts empty, and a code
  // arriving in that same cycle becomes entry 0 of the next frame so the
  // tap never loses a code at a frame boundary.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (xfer) begin
      buf_d = '0;
      cnt_d = 4'd0;
      ovf_d = 1'b0;
      if (dct_valid) begin
        buf_d[CODE_W-1:0] = dct_code;
        cnt_d             = 4'd1;
      end
    end else if (dct_valid) begin
      if (!full) begin
        buf_d[CODE_W*int'(cnt_q) +: CODE_W] = dct_code;
        cnt_d = cnt_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Buffer, count and overflow flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Pending flush. A new request wins over the clear from a transfer so a
  // flush arriving alongside a transfer still reaches the codes that
  // follow, and a held test_ending keeps draining whatever arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend_q <= 1'b0;
    end else if (flush || test_ending) begin
      flush_pend_q <= 1'b1;
    end else if (xfer) begin
      flush_pend_q <= 1'b0;
    end
  end

  // Test-end tracking. Once test_ending has been seen, the test is over
  // when the buffer and frame register are both empty and no code is
  // arriving; both flags then hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_seen_q <= 1'b0;
      ended_q     <= 1'b0;
    end else begin
      if (test_ending) begin
        test_seen_q <= 1'b1;
      end
      if (test_seen_q && (cnt_q == 4'd0) && !tw_valid && !dct_valid) begin
        ended_q <= 1'b1;
      end
    end
  end

`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
  // Saturating count of dropped codes, cleared only by reset so software
  // can read the total loss over the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= 8'd0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  nios_system_nios2_oci_dct_frame_reg u_frame_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .load_data (frame_in),
    .ready     (tw_ready),
    .valid     (tw_valid),
    .data      (frame_out),
    .slot_free (slot_free)
  );

  assign tw_data        = frame_out;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_nios_system_nios2_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_nios_system_nios2_oci_dct_packer
//
// Directed bench for the DCT packer. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so every check sees the
// state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_nios_system_nios2_oci_dct_packer;
  import nios_system_oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dct_code;
  logic        dct_valid;
  logic        flush;
  logic        test_ending;
  logic        tw_ready;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
  logic [7:0]  ovf_count;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  nios_system_nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .dct_code       (dct_code),
    .dct_valid      (dct_valid),
    .flush          (flush),
    .test_ending    (test_ending),
    .tw_ready       (tw_ready),
    .tw_valid       (tw_valid),
    .tw_data        (tw_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
    ,
    .ovf_count      (ovf_count)
`endif
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [35:0] observed,
                             input logic [35:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle worth of inputs and let the edge consume them.
  task automatic applyStimulus(input logic v, input logic [1:0] code,
                               input logic fl, input logic te, input logic rdy);
    dct_valid   = v;
    dct_code    = code;
    flush       = fl;
    test_ending = te;
    tw_ready    = rdy;
    tick();
  endtask

  task automatic applyReset;
    reset = 1'b1;
    dct_valid = 1'b0; dct_code = 2'b00; flush = 1'b0;
    test_ending = 1'b0; tw_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [35:0] expFrame(input logic ovf, input logic partial,
                                           input logic [3:0] cnt, input logic [29:0] buffer);
    return {ovf, partial, cnt, buffer};
  endfunction

  initial begin
    reset = 1'b1;
    dct_valid = 1'b0; dct_code = 2'b00; flush = 1'b0;
    test_ending = 1'b0; tw_ready = 1'b0;
    applyReset();

    // Reset state
    checkOutput("rst_tw_valid", tw_valid, 0);
    checkOutput("rst_tw_data", tw_data, 0);
    checkOutput("rst_dct_buffer", dct_buffer, 0);
    checkOutput("rst_dct_count", dct_count, 0);
    checkOutput("rst_ended", test_has_ended, 0);
`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
    checkOutput("rst_ovf_count", ovf_count, 0);
`endif

    // Fifteen TK codes fill the buffer and produce one full frame
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, TK, 1'b0, 1'b0, 1'b1);
    checkOutput("full_live_count", dct_count, 15);
    checkOutput("full_live_buffer", dct_buffer, 30'h2AAAAAAA);
    checkOutput("full_not_yet_valid", tw_valid, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("full_tw_valid", tw_valid, 1);
    checkOutput("full_frame", tw_data, expFrame(0, 0, 15, 30'h2AAAAAAA));
    checkOutput("full_count_cleared", dct_count, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("full_accepted", tw_valid, 0);

    // Partial frame on flush: NT, TK, IND -> 0x39
    applyStimulus(1'b1, NT, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, TK, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, IND, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_live_buffer", dct_buffer, 30'h39);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_no_frame_yet", tw_valid, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_tw_valid", tw_valid, 1);
    checkOutput("flush_frame", tw_data, expFrame(0, 1, 3, 30'h39));
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_accepted", tw_valid, 0);
    checkOutput("flush_count_cleared", dct_count, 0);

    // Stalled downstream: 15 TK then 17 NT, the last two dropped
    applyReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, (i < 15) ? TK : NT, 1'b0, 1'b0, 1'b0);
      if (i == 19) checkOutput("stall_frame_mid", tw_data, expFrame(0, 0, 15, 30'h2AAAAAAA));
    end
    checkOutput("stall_tw_valid", tw_valid, 1);
    checkOutput("stall_frame_held", tw_data, expFrame(0, 0, 15, 30'h2AAAAAAA));
    checkOutput("stall_live_count", dct_count, 15);
    checkOutput("stall_live_buffer", dct_buffer, 30'h15555555);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_ovf_frame", tw_data, expFrame(1, 0, 15, 30'h15555555));
    checkOutput("stall_ovf_tw_valid", tw_valid, 1);
`ifdef NIOS_SYSTEM_DCT_OVF_COUNT_EN
    checkOutput("stall_ovf_count", ovf_count, 2);
`endif
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_drained", tw_valid, 0);

    // Code arriving in the transfer cycle lands in entry 0; ovf was cleared
    applyReset();
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, IND, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, NT, 1'b0, 1'b0, 1'b1);
    checkOutput("xfer_code_frame", tw_data, expFrame(0, 0, 15, 30'h3FFFFFFF));
    checkOutput("xfer_code_count", dct_count, 1);
    checkOutput("xfer_code_buffer", dct_buffer, 30'h1);

    // Flush with an empty buffer stays pending until a code arrives
    applyReset();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_flush_no_frame", tw_valid, 0);
    applyStimulus(1'b1, TK, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_flush_count", dct_count, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_flush_tw_valid", tw_valid, 1);
    checkOutput("empty_flush_frame", tw_data, expFrame(0, 1, 1, 30'h2));

    // test_ending drains five codes, then test_has_ended rises and sticks
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, TK, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    checkOutput("end_tw_valid", tw_valid, 1);
    checkOutput("end_frame", tw_data, expFrame(0, 1, 5, 30'h2AA));
    checkOutput("end_not_yet", test_has_ended, 0);
    begin
      int budget = 0;
      while (!test_has_ended && budget < 8) begin
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        budget++;
      end
    end
    checkOutput("end_has_ended", test_has_ended, 1);
    checkOutput("end_drained", tw_valid, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, NT, 1'b0, 1'b0, 1'b0);
    checkOutput("end_sticky", test_has_ended, 1);

    // Reset mid-frame discards everything
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, TK, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_pre_valid", tw_valid, 1);
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_tw_valid", tw_valid, 0);
    checkOutput("midrst_tw_data", tw_data, 0);
    checkOutput("midrst_buffer", dct_buffer, 0);
    checkOutput("midrst_count", dct_count, 0);
    checkOutput("midrst_ended", test_has_ended, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_no_frame", tw_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
